// File: rtl/rotate_recover.sv
// Serial rotation decoder: captures a rotated word and undoes the rotation one bit per clock.
// The recovered word is held on data_out until the downstream handshake.
//
// state  | meaning
// IDLE   | ready for a new word (in_ready=1)
// ROTATE | rotating the working word one position per clock
// DONE   | data_out valid, waiting for out_ready
module rotate_recover #(
  parameter int WIDTH = 4,
  parameter int SHW   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shift_amt,
  input  logic             direction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             busy
);

  if (WIDTH != 2 ** SHW) begin : g_bad_params
    $error("rotate_recover: WIDTH must equal 2**SHW");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] word_q, word_nxt;
  logic [SHW-1:0]   cnt_q, cnt_nxt;
  logic             dir_q, dir_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      word_q <= '0;
      cnt_q  <= '0;
      dir_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      word_q <= word_nxt;
      cnt_q  <= cnt_nxt;
      dir_q  <= dir_nxt;
    end
  end

  // Undo runs opposite to the encoder: dir 0 -> rotate right, dir 1 -> rotate left.
  always_comb begin
    state_nxt = state;
    word_nxt  = word_q;
    cnt_nxt   = cnt_q;
    dir_nxt   = dir_q;
    case (state)
      IDLE: begin
        if (in_valid) begin
          word_nxt  = data_in;
          cnt_nxt   = shift_amt;
          dir_nxt   = direction;
          state_nxt = (shift_amt == '0) ? DONE : ROTATE;
        end
      end
      ROTATE: begin
        if (dir_q)
          word_nxt = {word_q[WIDTH-2:0], word_q[WIDTH-1]};
        else
          word_nxt = {word_q[0], word_q[WIDTH-1:1]};
        cnt_nxt = cnt_q - 1'b1;
        if (cnt_q == SHW'(1))
          state_nxt = DONE;
      end
      DONE: begin
        if (out_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign data_out  = word_q;

endmodule

// File: tb/tb_rotate_recover.sv
// Bench for rotate_recover: directed spec cases plus randomized traffic,
// all checked each cycle against a timestamp-based transaction model.
module tb_rotate_recover;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] data_in = '0;
  logic [1:0] shift_amt = '0;
  logic       direction = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] data_out;
  logic       busy;

  int errors = 0;
  int checks = 0;

  rotate_recover #(.WIDTH(4), .SHW(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .shift_amt(shift_amt), .direction(direction),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Recover the original word: the encoder rotated left (dir 0) or right (dir 1) by a.
  function automatic logic [3:0] recover(input logic [3:0] d, input int a, input logic dr);
    int v;
    v = int'(d);
    if (a == 0) return d;
    if (!dr) v = (v >> a) | (v << (4 - a));
    else     v = (v << a) | (v >> (4 - a));
    return 4'(v & 15);
  endfunction

  // Transaction model: one word in flight, valid from edge (accept + 1 + amt) until handshake.
  int         cyc = 0;
  bit         chk_en = 0;
  bit         m_pend = 0;
  bit         m_zero = 0;
  int         m_ready_at = 0;
  logic [3:0] m_exp = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_pend = 0;
      m_zero = 1;
      chk_en = 1;
    end else if (!m_pend) begin
      if (in_valid) begin
        m_pend     = 1;
        m_zero     = 0;
        m_exp      = recover(data_in, int'(shift_amt), direction);
        m_ready_at = cyc + 1 + int'(shift_amt);
      end
    end else if (cyc >= m_ready_at && out_ready) begin
      m_pend = 0;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", int'(in_ready), int'(!m_pend));
      chk("busy", int'(busy), int'(m_pend));
      chk("out_valid", int'(out_valid), int'(m_pend && cyc >= m_ready_at));
      if (m_pend && cyc >= m_ready_at) chk("data_out", int'(data_out), int'(m_exp));
      if (m_zero) chk("data_out_reset", int'(data_out), 0);
    end
  end

  task automatic send(input logic [3:0] d, input logic [1:0] a, input logic dr);
    bit ok;
    ok = 0;
    @(negedge clk);
    in_valid = 1'b1; data_in = d; shift_amt = a; direction = dr;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (in_ready) begin
        @(posedge clk);
        ok = 1;
      end else begin
        @(negedge clk);
      end
    end
    #1;
    in_valid = 1'b0; data_in = ~d; shift_amt = ~a; direction = ~dr;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (out_valid) return;
    end
    chk("valid_timeout", 0, 1);
  endtask

  initial begin
    int n;
    int b;
    repeat (2) @(negedge clk);
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_data", int'(data_out), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", int'(in_ready), 1);

    // Case 1
    out_ready = 1'b1;
    send(4'b1011, 2'd1, 1'b0);
    wait_valid(n);
    chk("c1_latency", n, 2);
    chk("c1_data", int'(data_out), 4'b1101);

    // Case 2
    send(4'b1011, 2'd3, 1'b1);
    b = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) chk("c2_data", int'(data_out), 4'b1101);
      if (busy) b++;
      else break;
    end
    chk("c2_busy_cycles", b, 4);

    // Case 3
    send(4'b1101, 2'd0, 1'b0);
    wait_valid(n);
    chk("c3_latency", n, 1);
    chk("c3_data", int'(data_out), 4'b1101);

    // Case 4: backpressure
    @(negedge clk);
    out_ready = 1'b0;
    send(4'b0111, 2'd2, 1'b0);
    wait_valid(n);
    chk("c4_latency", n, 3);
    repeat (5) begin
      @(negedge clk);
      chk("c4_hold_valid", int'(out_valid), 1);
      chk("c4_hold_data", int'(data_out), 4'b1101);
      chk("c4_hold_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("c4_release_valid", int'(out_valid), 0);
    chk("c4_release_ready", int'(in_ready), 1);

    // Case 5: reset mid-rotation
    send(4'b1011, 2'd3, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("c5_valid", int'(out_valid), 0);
    chk("c5_data", int'(data_out), 0);
    chk("c5_busy", int'(busy), 0);
    rst = 1'b0;
    send(4'b0110, 2'd1, 1'b1);
    wait_valid(n);
    chk("c5_latency", n, 2);
    chk("c5_data_after", int'(data_out), 4'b1100);

    // Case 6: in_valid held high, data changing every cycle
    repeat (300) begin
      @(negedge clk);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      data_in   = 4'($urandom);
      shift_amt = 2'($urandom);
      direction = 1'($urandom);
    end

    // Fully randomized traffic with backpressure and occasional reset
    repeat (3000) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      data_in   = 4'($urandom);
      shift_amt = 2'($urandom);
      direction = 1'($urandom);
      rst       = ($urandom_range(0, 99) == 0);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rotate_recover.md
ROTATE_RECOVER -- requirements
Module: rotate_recover

Interface
REQ-001 Parameter WIDTH, default 4, data word width in bits (WIDTH >= 2).
REQ-002 Parameter SHW, default 2, shift-amount width; WIDTH SHALL equal 2**SHW.
REQ-003 Port clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-004 Port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port in_valid  input  1  upstream offers a rotated word.
REQ-006 Port in_ready  output  1  block accepts a word this cycle.
REQ-007 Port data_in  input  WIDTH  word previously rotated by an encoder.
REQ-008 Port shift_amt  input  SHW  rotation amount the encoder applied.
REQ-009 Port direction  input  1  encoder direction: 0 = rotated left, 1 = rotated right.
REQ-010 Port out_valid  output  1  recovered word is present on data_out.
REQ-011 Port out_ready  input  1  downstream takes data_out this cycle.
REQ-012 Port data_out  output  WIDTH  recovered original word, registered.
REQ-013 Port busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 The block SHALL undo a rotation serially, moving one bit position per clock, opposite to the captured direction: right when direction=0, left when direction=1.
REQ-015 Rotation SHALL be circular; bits leaving one end SHALL re-enter at the other end, and no bit SHALL be lost or zero-filled.
REQ-016 The FSM SHALL have exactly three states: IDLE, ROTATE and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE, and SHALL be a function of state only.
REQ-018 Accept = in_valid && in_ready at an edge; that edge SHALL capture data_in, shift_amt and direction into internal registers.
REQ-019 On accept with shift_amt=0, the next state SHALL be DONE and data_out SHALL be loaded with data_in unchanged.
REQ-020 On accept with shift_amt!=0, the next state SHALL be ROTATE and the counter SHALL be loaded with shift_amt.
REQ-021 In ROTATE, each edge SHALL rotate the working word by one position and decrement the counter; the edge where the counter equals 1 SHALL move the state to DONE.
REQ-022 out_valid SHALL be asserted after the edge that falls shift_amt cycles after the accept edge (0 cycles when shift_amt=0), giving latency shift_amt+1 cycles.
REQ-023 In DONE, out_valid=1 and data_out SHALL be held stable until out_valid && out_ready at an edge; that edge SHALL return the state to IDLE.
REQ-024 Backpressure: with out_ready low, the block SHALL remain in DONE indefinitely with no change to data_out.
REQ-025 The earliest next accept SHALL be the cycle after the handshake edge; accept and output handshake SHALL never occur on the same edge.
REQ-026 in_valid SHALL be ignored, and inputs SHALL NOT be sampled, while in ROTATE or DONE.
REQ-027 A changing data_in, shift_amt or direction after the accept edge SHALL NOT affect the word in flight.
REQ-028 A shift_amt equal to WIDTH-1 SHALL complete in WIDTH-1 rotate cycles and SHALL NOT wrap the counter.

Reset
REQ-029 With rst=1 at an edge: state SHALL be IDLE, out_valid=0, busy=0, data_out=0, counter=0, and all capture registers SHALL be 0.
REQ-030 rst SHALL take priority over every handshake, including a reset asserted mid-ROTATE or in DONE; the in-flight word SHALL be discarded.
REQ-031 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification (WIDTH=4)
REQ-032 Case 1: data_in=1011, shift_amt=01, direction=0, out_ready=1 -> data_out=1101, with out_valid asserted 1 edge after accept.
REQ-033 Case 2: data_in=1011, shift_amt=11, direction=1 -> data_out=1101 after 3 rotate cycles; busy is high for 4 cycles in total.
REQ-034 Case 3: data_in=1101, shift_amt=00 -> data_out=1101, with out_valid high in the cycle after accept.
REQ-035 Case 4: data_in=0111, shift_amt=10, direction=0, out_ready=0 for 5 cycles -> out_valid stays 1, data_out stays 1101, and in_ready stays 0 until the handshake.
REQ-036 Case 5: rst pulsed during ROTATE -> out_valid=0 and data_out=0000 on the next cycle; a new accept then succeeds and produces correct data.
REQ-037 Case 6: in_valid held high across back-to-back words, with data_in changed mid-rotation -> each output matches only its accepted input, and no word is dropped or duplicated.
